// File: rtl/nova_bs_pkg.sv
// rtl/nova_bs_pkg.sv - shared types, defaults and helpers for the bitstream prefetch buffer
//
// Purpose: default widths, the bitstream word type, the read-request
// classification enum and the modular address difference helper used by
// bitstream_prefetch_buf.
// Ports: none (package).
package nova_bs_pkg;

  localparam int BS_DATA_W     = 16;
  localparam int BS_ADDR_W     = 17;
  localparam int BS_DEPTH_LOG2 = 10;

  typedef logic [BS_DATA_W-1:0] bs_word_t;

  // Outcome of a decoder read request in the current cycle.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STALL,
    RD_STALE,
    RD_ACCEPT
  } bs_rd_kind_t;

  // a - b modulo 2^32; callers truncate to their own address width, which
  // keeps the result correct modulo 2^ADDR_W.
  function automatic logic [31:0] bs_addr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/bs_buf_dpram.sv
// rtl/bs_buf_dpram.sv - simple dual-port RAM, one write port, one registered read port
//
// Purpose: 2^AW x DATA_W storage for the prefetch buffer. The read register
// only loads on i_rd_en, so it holds its value across stalled requests, and
// i_rd_clr forces it to zero (reset/flush). Memory contents are never cleared.
// Ports:
//   i_clk                  clock
//   i_wr_en/i_wr_addr/i_wr_data   write port
//   i_rd_en/i_rd_addr      registered read request
//   i_rd_clr               synchronous clear of the read register (priority)
//   o_rd_data              read data, valid the cycle after i_rd_en
module bs_buf_dpram #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_rd_clr,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_clr) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bitstream_prefetch_buf.sv
// rtl/bitstream_prefetch_buf.sv - circular bitstream prefetch buffer with stall, back-pressure and stale detection
//
// Purpose: fills a 2^DEPTH_LOG2-word circular buffer from an upstream
// valid/ready word stream and serves the decoder's absolute-address
// BitStream_ram read port. Requests ahead of the write pointer stall, writes
// are back-pressured once the buffer is full relative to the last accepted
// read, and reads of already-overwritten words raise a sticky stale_err.
// Optional macro BS_PREFETCH_STATS_EN adds saturating stall_cycles and
// words_in counters.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   in_valid/in_data/in_ready   upstream word stream
//   flush                  synchronous pointer clear for a new stream
//   BitStream_ram_ren      decoder read enable (active-low)
//   BitStream_ram_addr     decoder absolute word address
//   BitStream_ram_data     read data, one cycle after an accepted read
//   bs_stall               requested word not yet written
//   level                  words held (wr_cnt - rd_base), saturated
//   stale_err              sticky overwritten-word read flag
//   stall_cycles, words_in (BS_PREFETCH_STATS_EN only) statistics
module bitstream_prefetch_buf
  import nova_bs_pkg::*;
#(
  parameter int DATA_W     = BS_DATA_W,
  parameter int ADDR_W     = BS_ADDR_W,
  parameter int DEPTH_LOG2 = BS_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  BitStream_ram_ren,
  input  logic [ADDR_W-1:0]     BitStream_ram_addr,
  output logic [DATA_W-1:0]     BitStream_ram_data,
  output logic                  bs_stall,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  stale_err
`ifdef BS_PREFETCH_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           words_in
`endif
);

  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(1 << DEPTH_LOG2);

  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_base;
  logic              r_stale_err;

  logic [ADDR_W-1:0] w_d;
  logic [ADDR_W-1:0] w_back;
  logic [ADDR_W-1:0] w_used;
  logic              w_clr;
  logic              w_wr_en;
  logic              w_rd_en;
  bs_rd_kind_t       w_rd_kind;

  // w_d = addr - wr_cnt; a non-negative signed value means the word has not
  // been written yet. w_back = wr_cnt - addr is how far behind the writer
  // the request sits.
  assign w_d    = ADDR_W'(bs_addr_diff(32'(BitStream_ram_addr), 32'(r_wr_cnt)));
  assign w_back = '0 - w_d;
  assign w_used = ADDR_W'(bs_addr_diff(32'(r_wr_cnt), 32'(r_rd_base)));
  assign w_clr  = !reset_n || flush;

  always_comb begin
    w_rd_kind = RD_IDLE;
    if (!BitStream_ram_ren) begin
      if (!w_d[ADDR_W-1]) begin
        w_rd_kind = RD_STALL;
      end else if (w_back > L_DEPTH) begin
        w_rd_kind = RD_STALE;
      end else begin
        w_rd_kind = RD_ACCEPT;
      end
    end
  end

  // Space is measured against rd_base (the last accepted read), so the word
  // just behind the decoder is never overwritten and a backtrack of one works.
  assign in_ready  = (w_used < L_DEPTH) && !flush;
  assign w_wr_en   = in_valid && in_ready;
  // Stale reads still return RAM contents; only stalls suppress the load.
  assign w_rd_en   = (w_rd_kind == RD_ACCEPT) || (w_rd_kind == RD_STALE);
  assign bs_stall  = (w_rd_kind == RD_STALL) && !w_clr;
  assign level     = (w_used > L_DEPTH) ? L_DEPTH[DEPTH_LOG2:0] : w_used[DEPTH_LOG2:0];
  assign stale_err = r_stale_err;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_cnt    <= '0;
      r_rd_base   <= '0;
      r_stale_err <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_rd_kind == RD_ACCEPT) begin
        r_rd_base <= BitStream_ram_addr;
      end
      if (w_rd_kind == RD_STALE) begin
        r_stale_err <= 1'b1;
      end
    end
  end

  bs_buf_dpram #(
    .DATA_W (DATA_W),
    .AW     (DEPTH_LOG2)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_cnt[DEPTH_LOG2-1:0]),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_clr),
    .i_rd_addr (BitStream_ram_addr[DEPTH_LOG2-1:0]),
    .o_rd_data (BitStream_ram_data)
  );

`ifdef BS_PREFETCH_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_words_in;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_stall_cycles <= '0;
      r_words_in     <= '0;
    end else begin
      if (bs_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_wr_en && (r_words_in != '1)) begin
        r_words_in <= r_words_in + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign words_in     = r_words_in;
`endif

endmodule

// File: tb/tb_bitstream_prefetch_buf.sv
// tb/tb_bitstream_prefetch_buf.sv - scoreboard bench for bitstream_prefetch_buf
module tb_bitstream_prefetch_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Instance A: ADDR_W=17, DEPTH_LOG2=4
  logic        a_in_valid;
  logic [15:0] a_in_data;
  logic        a_in_ready;
  logic        a_flush;
  logic        a_ren;
  logic [16:0] a_addr;
  logic [15:0] a_data;
  logic        a_stall;
  logic [4:0]  a_level;
  logic        a_stale;

  // Instance B: ADDR_W=5, DEPTH_LOG2=3
  logic        b_in_valid;
  logic [15:0] b_in_data;
  logic        b_in_ready;
  logic        b_flush;
  logic        b_ren;
  logic [4:0]  b_addr;
  logic [15:0] b_data;
  logic        b_stall;
  logic [3:0]  b_level;
  logic        b_stale;

`ifdef BS_PREFETCH_STATS_EN
  logic [31:0] a_stall_cycles, a_words_in, b_stall_cycles, b_words_in;
`endif

  bitstream_prefetch_buf #(.DATA_W(16), .ADDR_W(17), .DEPTH_LOG2(4)) u_dut_a (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (a_in_valid),
    .in_data            (a_in_data),
    .in_ready           (a_in_ready),
    .flush              (a_flush),
    .BitStream_ram_ren  (a_ren),
    .BitStream_ram_addr (a_addr),
    .BitStream_ram_data (a_data),
    .bs_stall           (a_stall),
    .level              (a_level),
    .stale_err          (a_stale)
`ifdef BS_PREFETCH_STATS_EN
    ,
    .stall_cycles       (a_stall_cycles),
    .words_in           (a_words_in)
`endif
  );

  bitstream_prefetch_buf #(.DATA_W(16), .ADDR_W(5), .DEPTH_LOG2(3)) u_dut_b (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (b_in_valid),
    .in_data            (b_in_data),
    .in_ready           (b_in_ready),
    .flush              (b_flush),
    .BitStream_ram_ren  (b_ren),
    .BitStream_ram_addr (b_addr),
    .BitStream_ram_data (b_data),
    .bs_stall           (b_stall),
    .level              (b_level),
    .stale_err          (b_stale)
`ifdef BS_PREFETCH_STATS_EN
    ,
    .stall_cycles       (b_stall_cycles),
    .words_in           (b_words_in)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        a_pend = 1'b0;
  logic        b_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a request seen un-stalled at one negedge must show its data at
  // the next negedge.
  always @(negedge clk) begin
    if (a_pend) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_rd_data: got 0x%0h with no read expected", a_data);
      end else begin
        chk("a_rd_data", 32'(a_data), 32'(qa.pop_front()));
      end
    end
    a_pend = reset_n && !a_ren && !a_stall;
  end

  always @(negedge clk) begin
    if (b_pend) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_rd_data: got 0x%0h with no read expected", b_data);
      end else begin
        chk("b_rd_data", 32'(b_data), 32'(qb.pop_front()));
      end
    end
    b_pend = reset_n && !b_ren && !b_stall;
  end

  task automatic a_drv(input logic v, input logic [15:0] d, input logic rn,
                       input logic [16:0] ad, input logic fl);
    @(posedge clk);
    #2;
    a_in_valid = v;
    a_in_data  = d;
    a_ren      = rn;
    a_addr     = ad;
    a_flush    = fl;
    #1;
  endtask

  task automatic a_idle();
    a_drv(1'b0, 16'h0, 1'b1, 17'd0, 1'b0);
  endtask

  task automatic b_drv(input logic v, input logic [15:0] d, input logic rn,
                       input logic [4:0] ad, input logic fl);
    @(posedge clk);
    #2;
    b_in_valid = v;
    b_in_data  = d;
    b_ren      = rn;
    b_addr     = ad;
    b_flush    = fl;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_ren = 1'b0; a_addr = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_ren = 1'b1; b_addr = '0;

    // Reset state, with a read of an unwritten word held during reset.
    repeat (2) @(posedge clk);
    #3;
    chk("a_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("a_rst_level",    32'(a_level),    32'd0);
    chk("a_rst_stall",    32'(a_stall),    32'd0);
    chk("a_rst_stale",    32'(a_stale),    32'd0);
    chk("a_rst_data",     32'(a_data),     32'd0);
    chk("b_rst_level",    32'(b_level),    32'd0);
    chk("b_rst_in_ready", 32'(b_in_ready), 32'd1);
    a_ren   = 1'b1;
    reset_n = 1'b1;

    // Push 0x1000..0x1003, read back 0..3.
    for (int i = 0; i < 4; i++) a_drv(1'b1, 16'(16'h1000 + i), 1'b1, 17'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_drv(1'b0, 16'h0, 1'b0, 17'(i), 1'b0);
      qa.push_back(16'(16'h1000 + i));
      chk("a_t1_stall", 32'(a_stall), 32'd0);
    end
    a_idle();
    chk("a_t1_level", 32'(a_level), 32'd1);

    // Underrun: read addr 5 with wr_cnt=4.
    a_drv(1'b0, 16'h0, 1'b0, 17'd5, 1'b0);
    qa.push_back(16'h1005);
    chk("a_t2_stall_wr4", 32'(a_stall), 32'd1);
    a_drv(1'b1, 16'h1004, 1'b0, 17'd5, 1'b0);
    chk("a_t2_stall_wr4b", 32'(a_stall), 32'd1);
    a_drv(1'b1, 16'h1005, 1'b0, 17'd5, 1'b0);
    chk("a_t2_stall_wr5", 32'(a_stall), 32'd1);
    a_drv(1'b0, 16'h0, 1'b0, 17'd5, 1'b0);
    chk("a_t2_stall_wr6", 32'(a_stall), 32'd0);
    a_idle();
    chk("a_t2_level", 32'(a_level), 32'd1);

    // Full buffer back-pressure.
    a_drv(1'b0, 16'h0, 1'b1, 17'd0, 1'b1);
    chk("a_t3_flush_in_ready", 32'(a_in_ready), 32'd0);
    a_idle();
    chk("a_t3_level0", 32'(a_level), 32'd0);
    chk("a_t3_in_ready0", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 16; i++) a_drv(1'b1, 16'(16'h2000 + i), 1'b1, 17'd0, 1'b0);
    a_drv(1'b1, 16'h0BAD, 1'b0, 17'd0, 1'b0);
    qa.push_back(16'h2000);
    chk("a_t3_level_full", 32'(a_level), 32'd16);
    chk("a_t3_in_ready_full", 32'(a_in_ready), 32'd0);
    a_drv(1'b0, 16'h0, 1'b0, 17'd1, 1'b0);
    qa.push_back(16'h2001);
    chk("a_t3_level_rd0", 32'(a_level), 32'd16);
    chk("a_t3_in_ready_rd0", 32'(a_in_ready), 32'd0);
    a_idle();
    chk("a_t3_level_rd1", 32'(a_level), 32'd15);
    chk("a_t3_in_ready_rd1", 32'(a_in_ready), 32'd1);

    // Stale read detection.
    a_drv(1'b0, 16'h0, 1'b1, 17'd0, 1'b1);
    a_idle();
    for (int i = 0; i <= 20; i++) begin
      a_drv(i < 20, 16'(16'h3000 + i), i == 0, 17'(i - 1), 1'b0);
      if (i > 0) begin
        qa.push_back(16'(16'h3000 + i - 1));
        chk("a_t4_stall", 32'(a_stall), 32'd0);
      end
    end
    a_drv(1'b0, 16'h0, 1'b0, 17'd4, 1'b0);
    qa.push_back(16'h3004);
    a_drv(1'b0, 16'h0, 1'b0, 17'd1, 1'b0);
    qa.push_back(16'h3011);
    chk("a_t4_stale_edge", 32'(a_stale), 32'd0);
    chk("a_t4_level_edge", 32'(a_level), 32'd16);
    chk("a_t4_stall_stale", 32'(a_stall), 32'd0);
    a_idle();
    chk("a_t4_stale_set", 32'(a_stale), 32'd1);
    repeat (3) a_idle();
    chk("a_t4_stale_sticky", 32'(a_stale), 32'd1);

    // Flush clears stale; flush beats a simultaneous write.
    a_drv(1'b0, 16'h0, 1'b1, 17'd0, 1'b1);
    chk("a_t6_flush_in_ready", 32'(a_in_ready), 32'd0);
    a_idle();
    chk("a_t6_stale_clr", 32'(a_stale), 32'd0);
    chk("a_t6_data_clr",  32'(a_data),  32'd0);
    for (int i = 0; i < 5; i++) a_drv(1'b1, 16'(16'h5000 + i), 1'b1, 17'd0, 1'b0);
    a_idle();
    chk("a_t6_level5", 32'(a_level), 32'd5);
    a_drv(1'b1, 16'h5555, 1'b1, 17'd0, 1'b1);
    chk("a_t6_in_ready_flush", 32'(a_in_ready), 32'd0);
    a_drv(1'b0, 16'h0, 1'b0, 17'd0, 1'b0);
    chk("a_t6_level0", 32'(a_level), 32'd0);
    chk("a_t6_in_ready", 32'(a_in_ready), 32'd1);
    chk("a_t6_stall_addr0", 32'(a_stall), 32'd1);
    a_drv(1'b1, 16'h6000, 1'b0, 17'd0, 1'b0);
    qa.push_back(16'h6000);
    chk("a_t6_stall_wr0", 32'(a_stall), 32'd1);
    a_drv(1'b0, 16'h0, 1'b0, 17'd0, 1'b0);
    chk("a_t6_stall_wr1", 32'(a_stall), 32'd0);
    a_idle();

    // Address wrap on the narrow instance.
    for (int i = 0; i <= 40; i++) begin
      b_drv(i < 40, 16'(16'h7000 + i), i == 0, 5'(i - 1), 1'b0);
      if (i > 0) begin
        qb.push_back(16'(16'h7000 + i - 1));
        chk("b_t5_stall", 32'(b_stall), 32'd0);
      end
    end
    b_drv(1'b0, 16'h0, 1'b1, 5'd0, 1'b0);
    chk("b_t5_stale", 32'(b_stale), 32'd0);
    chk("b_t5_level", 32'(b_level), 32'd1);

    repeat (3) @(posedge clk);
    #3;
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
